// File: rtl/thor2021_branch_predictor_pkg.sv
// Shared configuration, types and counter helper for the Thor2021 gshare predictor.
package thor2021_branch_predictor_pkg;

    localparam int ADDR_W   = 32;
    localparam int TBL_BITS = 9;
    localparam int TBL_SIZE = 1 << TBL_BITS;
    localparam int QDEPTH   = 8;
    localparam int QTAG     = $clog2(QDEPTH);
    localparam int QPTR     = QTAG + 1;

    typedef logic [1:0] bp_ctr_t;
    localparam bp_ctr_t CTR_WEAK_NT = 2'b01;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    typedef struct packed {
        logic                valid;
        logic                resolved;
        logic                pred;
        logic                actual;
        logic [TBL_BITS-1:0] idx;
        logic [TBL_BITS-1:0] ghr;
    } bp_slot_t;

    // Two-bit saturating counter step; 00 and 11 hold.
    function automatic bp_ctr_t ctr_update(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/thor2021_bp_queue.sv
// In-flight prediction queue: circular slot array with allocate, resolve/flush and
// in-order retire of resolved head entries.
module thor2021_bp_queue
    import thor2021_branch_predictor_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic [TBL_BITS-1:0] alloc_idx_i,
    input  logic [TBL_BITS-1:0] alloc_ghr_i,
    input  logic                alloc_pred_i,
    input  logic                res_valid_i,
    input  logic [QTAG-1:0]     res_tag_i,
    input  logic                res_takb_i,
    output logic                full_o,
    output logic [QTAG-1:0]     tail_tag_o,
    output logic                flush_o,
    output logic [TBL_BITS-1:0] flush_ghr_o,
    output logic                flush_actual_o,
    output logic                retire_o,
    output logic [TBL_BITS-1:0] retire_idx_o,
    output logic                retire_actual_o
);

    bp_slot_t        slots_q [QDEPTH];
    bp_slot_t        slots_d [QDEPTH];
    logic [QPTR-1:0] head_q, head_d;
    logic [QPTR-1:0] tail_q, tail_d;

    logic [QTAG-1:0] head_tag;
    logic [QTAG-1:0] res_off;
    logic [QTAG-1:0] slot_off;
    bp_slot_t        res_slot;
    logic            res_hit;

    assign head_tag   = head_q[QTAG-1:0];
    assign tail_tag_o = tail_q[QTAG-1:0];
    assign full_o     = (tail_q - head_q) == QPTR'(QDEPTH);

    // NOTE: combinational blocks use blocking '=', clocked blocks use '<=' only.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        slots_d         = slots_q;
        head_d          = head_q;
        tail_d          = tail_q;
        flush_o         = 1'b0;
        flush_ghr_o     = '0;
        flush_actual_o  = 1'b0;
        res_off         = '0;
        slot_off        = '0;
        res_slot        = slots_q[res_tag_i];
        res_hit         = res_valid_i & res_slot.valid & ~res_slot.resolved;
        retire_o        = slots_q[head_tag].valid & slots_q[head_tag].resolved;
        retire_idx_o    = slots_q[head_tag].idx;
        retire_actual_o = slots_q[head_tag].actual;

        if (retire_o) begin
            slots_d[head_tag].valid    = 1'b0;
            slots_d[head_tag].resolved = 1'b0;
            head_d                     = head_q + QPTR'(1);
        end

        if (res_hit) begin
            slots_d[res_tag_i].resolved = 1'b1;
            slots_d[res_tag_i].actual   = res_takb_i;
            if (res_takb_i != res_slot.pred) begin
                flush_o        = 1'b1;
                flush_ghr_o    = res_slot.ghr;
                flush_actual_o = res_takb_i;
                // Age is distance from head; anything further out than the
                // mispredicted slot is on the wrong path.
                res_off = res_tag_i - head_tag;
                for (int i = 0; i < QDEPTH; i++) begin
                    slot_off = QTAG'(i) - head_tag;
                    if (slot_off > res_off) begin
                        slots_d[i].valid    = 1'b0;
                        slots_d[i].resolved = 1'b0;
                    end
                end
                tail_d = head_q + QPTR'(res_off) + QPTR'(1);
            end
        end

        if (alloc_i && !flush_o) begin
            slots_d[tail_tag_o] = '{valid:    1'b1,
                                    resolved: 1'b0,
                                    pred:     alloc_pred_i,
                                    actual:   1'b0,
                                    idx:      alloc_idx_i,
                                    ghr:      alloc_ghr_i};
            tail_d = tail_q + QPTR'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            slots_q <= slots_d;
        end
    end

endmodule

// File: rtl/thor2021_branch_predictor.sv
// gshare direction predictor for Thor2021 fetch: pattern table, global history,
// init sweep FSM and the in-flight prediction queue.
module thor2021_branch_predictor
    import thor2021_branch_predictor_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pred_req_i,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_ready_o,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [QTAG-1:0]   pred_tag_o,
    input  logic              res_valid_i,
    input  logic [QTAG-1:0]   res_tag_i,
    input  logic              res_takb_i,
    output logic              mispredict_o,
    output logic [QTAG-1:0]   mispredict_tag_o
);

    bp_state_t           state_q, state_d;
    logic [TBL_BITS-1:0] init_idx_q, init_idx_d;
    logic [TBL_BITS-1:0] ghr_q, ghr_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [QTAG-1:0]     pred_tag_q, pred_tag_d;
    logic                mispredict_q, mispredict_d;
    logic [QTAG-1:0]     mispredict_tag_q, mispredict_tag_d;

    bp_ctr_t             ctr_q [TBL_SIZE];
    logic                tbl_we;
    logic [TBL_BITS-1:0] tbl_waddr;
    bp_ctr_t             tbl_wdata;

    logic [TBL_BITS-1:0] pred_idx;
    logic                pred_bit;
    logic                run;
    logic                accept;

    logic                q_full;
    logic [QTAG-1:0]     q_tail_tag;
    logic                q_flush;
    logic [TBL_BITS-1:0] q_flush_ghr;
    logic                q_flush_actual;
    logic                q_retire;
    logic [TBL_BITS-1:0] q_retire_idx;
    logic                q_retire_actual;

    logic                unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[ADDR_W-1:TBL_BITS+1], pred_pc_i[0]};

    assign run          = (state_q == BP_RUN);
    assign pred_idx     = pred_pc_i[TBL_BITS:1] ^ ghr_q;
    assign pred_bit     = ctr_q[pred_idx][1];
    assign pred_ready_o = run & ~q_full & ~mispredict_q;
    assign accept       = pred_req_i & pred_ready_o;

    thor2021_bp_queue u_queue (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .alloc_i         (accept),
        .alloc_idx_i     (pred_idx),
        .alloc_ghr_i     (ghr_q),
        .alloc_pred_i    (pred_bit),
        .res_valid_i     (res_valid_i & run),
        .res_tag_i       (res_tag_i),
        .res_takb_i      (res_takb_i),
        .full_o          (q_full),
        .tail_tag_o      (q_tail_tag),
        .flush_o         (q_flush),
        .flush_ghr_o     (q_flush_ghr),
        .flush_actual_o  (q_flush_actual),
        .retire_o        (q_retire),
        .retire_idx_o    (q_retire_idx),
        .retire_actual_o (q_retire_actual)
    );

    always_comb begin
        state_d          = state_q;
        init_idx_d       = init_idx_q;
        ghr_d            = ghr_q;
        pred_valid_d     = 1'b0;
        pred_taken_d     = 1'b0;
        pred_tag_d       = '0;
        mispredict_d     = 1'b0;
        mispredict_tag_d = '0;
        tbl_we           = 1'b0;
        tbl_waddr        = '0;
        tbl_wdata        = '0;

        unique case (state_q)
            BP_INIT: begin
                tbl_we     = 1'b1;
                tbl_waddr  = init_idx_q;
                tbl_wdata  = CTR_WEAK_NT;
                init_idx_d = init_idx_q + TBL_BITS'(1);
                if (init_idx_q == '1) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                if (q_retire) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = q_retire_idx;
                    tbl_wdata = ctr_update(ctr_q[q_retire_idx], q_retire_actual);
                end
                // A mispredict repairs history and drops any same-cycle allocation.
                if (q_flush) begin
                    ghr_d            = {q_flush_ghr[TBL_BITS-2:0], q_flush_actual};
                    mispredict_d     = 1'b1;
                    mispredict_tag_d = res_tag_i;
                end else if (accept) begin
                    ghr_d        = {ghr_q[TBL_BITS-2:0], pred_bit};
                    pred_valid_d = 1'b1;
                    pred_taken_d = pred_bit;
                    pred_tag_d   = q_tail_tag;
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= BP_INIT;
            init_idx_q       <= '0;
            ghr_q            <= '0;
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_tag_q       <= '0;
            mispredict_q     <= 1'b0;
            mispredict_tag_q <= '0;
        end else begin
            state_q          <= state_d;
            init_idx_q       <= init_idx_d;
            ghr_q            <= ghr_d;
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_tag_q       <= pred_tag_d;
            mispredict_q     <= mispredict_d;
            mispredict_tag_q <= mispredict_tag_d;
        end
    end

    // NOTE: the table has no reset; the INIT sweep writes every entry before RUN.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            ctr_q[tbl_waddr] <= tbl_wdata;
        end
    end

    assign pred_valid_o     = pred_valid_q;
    assign pred_taken_o     = pred_taken_q;
    assign pred_tag_o       = pred_tag_q;
    assign mispredict_o     = mispredict_q;
    assign mispredict_tag_o = mispredict_tag_q;

endmodule

// File: tb/tb_thor2021_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a list-based
// reference model of the gshare predictor and its in-flight queue.
module tb_thor2021_branch_predictor;

    localparam int NTBL = 512;
    localparam int NQ   = 8;

    logic        clk_i;
    logic        rst_ni;
    logic        pred_req_i;
    logic [31:0] pred_pc_i;
    logic        pred_ready_o;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [2:0]  pred_tag_o;
    logic        res_valid_i;
    logic [2:0]  res_tag_i;
    logic        res_takb_i;
    logic        mispredict_o;
    logic [2:0]  mispredict_tag_o;

    thor2021_branch_predictor dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pred_req_i       (pred_req_i),
        .pred_pc_i        (pred_pc_i),
        .pred_ready_o     (pred_ready_o),
        .pred_valid_o     (pred_valid_o),
        .pred_taken_o     (pred_taken_o),
        .pred_tag_o       (pred_tag_o),
        .res_valid_i      (res_valid_i),
        .res_tag_i        (res_tag_i),
        .res_takb_i       (res_takb_i),
        .mispredict_o     (mispredict_o),
        .mispredict_tag_o (mispredict_tag_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight branches kept as an ordered list, oldest first.
    typedef struct {
        int tag;
        int idx;
        int ghr;
        bit pred;
        bit resolved;
        bit actual;
    } ent_t;

    ent_t mq[$];
    int   pht[NTBL];
    int   m_ghr;
    int   next_tag;
    int   init_cnt;
    bit   mp_pend;
    bit   exp_valid, exp_taken, exp_mp;
    int   exp_tag, exp_mp_tag;

    task automatic model_reset();
        mq.delete();
        m_ghr = 0; next_tag = 0; init_cnt = 0; mp_pend = 0;
        exp_valid = 0; exp_taken = 0; exp_tag = 0; exp_mp = 0; exp_mp_tag = 0;
    endtask

    task automatic model_step(input bit req, input logic [31:0] pc, input bit rv,
                              input int rtag, input bit rtakb, output bit ready);
        bit run, do_retire, flush, p, found;
        int idx;
        ent_t e;
        run   = init_cnt >= NTBL;
        ready = run && mq.size() < NQ && !mp_pend;
        exp_valid = 0; exp_taken = 0; exp_tag = 0; exp_mp = 0; exp_mp_tag = 0;
        if (!run) begin
            pht[init_cnt] = 1;
            init_cnt++;
        end else begin
            do_retire = mq.size() > 0 && mq[0].resolved;
            flush = 0;
            found = 0;
            idx = ((pc >> 1) & (NTBL - 1)) ^ m_ghr;
            p = pht[idx] >= 2;
            if (rv) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (!found && mq[k].tag == rtag) begin
                        found = 1;
                        if (!mq[k].resolved) begin
                            mq[k].resolved = 1;
                            mq[k].actual = rtakb;
                            if (rtakb != mq[k].pred) begin
                                flush = 1;
                                m_ghr = ((mq[k].ghr << 1) | int'(rtakb)) & (NTBL - 1);
                                next_tag = (rtag + 1) % NQ;
                                exp_mp = 1;
                                exp_mp_tag = rtag;
                                mq = mq[0:k];
                            end
                        end
                    end
                end
            end
            if (!flush && req && ready) begin
                mq.push_back('{next_tag, idx, m_ghr, p, 1'b0, 1'b0});
                exp_valid = 1;
                exp_taken = p;
                exp_tag = next_tag;
                m_ghr = ((m_ghr << 1) | int'(p)) & (NTBL - 1);
                next_tag = (next_tag + 1) % NQ;
            end
            if (do_retire) begin
                e = mq.pop_front();
                if (e.actual) pht[e.idx] = (pht[e.idx] == 3) ? 3 : pht[e.idx] + 1;
                else          pht[e.idx] = (pht[e.idx] == 0) ? 0 : pht[e.idx] - 1;
            end
        end
        mp_pend = exp_mp;
    endtask

    // One clock: drive at negedge, check ready before the edge, outputs after it.
    task automatic step(input bit req, input logic [31:0] pc, input bit rv,
                        input int rtag, input bit rtakb);
        bit rdy;
        pred_req_i  = req;
        pred_pc_i   = pc;
        res_valid_i = rv;
        res_tag_i   = 3'(rtag);
        res_takb_i  = rtakb;
        model_step(req, pc, rv, rtag, rtakb, rdy);
        #1;
        check("pred_ready", pred_ready_o, rdy);
        @(posedge clk_i);
        @(negedge clk_i);
        check("pred_valid", pred_valid_o, exp_valid);
        if (exp_valid) begin
            check("pred_taken", pred_taken_o, exp_taken);
            check("pred_tag", pred_tag_o, exp_tag);
        end
        check("mispredict", mispredict_o, exp_mp);
        if (exp_mp) check("mispredict_tag", mispredict_tag_o, exp_mp_tag);
    endtask

    task automatic idle(input int n, input bit req);
        for (int i = 0; i < n; i++) step(req, $urandom, 0, 0, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && mq.size() > 0; n++) begin
            if (!mq[0].resolved) step(0, 0, 1, mq[0].tag, mq[0].pred);
            else                 step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, pred_ready_o, 0);
        check({tag, "_valid"}, pred_valid_o, 0);
        check({tag, "_taken"}, pred_taken_o, 0);
        check({tag, "_tag"}, pred_tag_o, 0);
        check({tag, "_mp"}, mispredict_o, 0);
        check({tag, "_mp_tag"}, mispredict_tag_o, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        pred_req_i = 0; pred_pc_i = 0; res_valid_i = 0; res_tag_i = 0; res_takb_i = 0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        model_reset();
        rst_ni = 1'b1;
    endtask

    initial begin
        int k, t3;
        rst_ni = 1'b1;
        pred_req_i = 0; pred_pc_i = 0; res_valid_i = 0; res_tag_i = 0; res_takb_i = 0;
        #2;
        apply_reset();

        // Init sweep holds ready low with a request pending, then first predict is not-taken.
        idle(NTBL, 1);
        step(1, 32'h0000_0040, 0, 0, 0);
        drain();

        // Repeated taken training of one PC until the counter saturates.
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h0000_0100, 0, 0, 0);
            step(0, 0, 1, mq[mq.size()-1].tag, 1);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        drain();

        // Fill to full, retire head, tags wrap.
        for (int i = 0; i < NQ; i++) step(1, $urandom, 0, 0, 0);
        step(1, $urandom, 1, mq[0].tag, mq[0].pred);
        step(1, $urandom, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0, 0);
        drain();

        // Mispredict on second of five entries; stale resolve afterwards ignored.
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, 0);
        t3 = mq[3].tag;
        step(0, 0, 1, mq[1].tag, !mq[1].pred);
        step(1, $urandom, 1, t3, $urandom_range(0, 1));
        step(1, $urandom, 0, 0, 0);
        drain();

        // Request in the same cycle as a mispredicting resolve is dropped.
        for (int i = 0; i < 2; i++) step(1, $urandom, 0, 0, 0);
        step(1, $urandom, 1, mq[0].tag, !mq[0].pred);
        step(0, 0, 0, 0, 0);
        drain();

        // Reset mid-run with entries queued; queue is empty after the new sweep.
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, 0);
        apply_reset();
        idle(NTBL, 1);
        for (int i = 0; i < NQ; i++) step(0, 0, 1, i, $urandom_range(0, 1));
        step(1, $urandom, 0, 0, 0);
        drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit req, rv, takb;
            int tag;
            req = ($urandom_range(0, 9) < 6);
            rv = 0; tag = 0; takb = 0;
            if ($urandom_range(0, 9) < 5) begin
                rv = 1;
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    k = $urandom_range(0, mq.size() - 1);
                    tag = mq[k].tag;
                    takb = ($urandom_range(0, 3) == 0) ? !mq[k].pred : mq[k].pred;
                end else begin
                    tag = $urandom_range(0, NQ - 1);
                    takb = $urandom_range(0, 1);
                end
            end
            step(req, $urandom, rv, tag, takb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
